// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the M-stage data-memory responder: MMIO register
// offsets (relative to the MMIO base), STATUS register bit positions and the
// default MMIO base address.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    // Word offsets inside the MMIO region.
    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_CYCLE  = 16'h0004;
    localparam logic [15:0] OFF_STORES = 16'h0008;
    localparam logic [15:0] OFF_TXDATA = 16'h0010;
    localparam logic [15:0] OFF_STATUS = 16'h0014;

    // STATUS register layout.
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_COUNT_LSB = 2;
    localparam int ST_COUNT_MSB = 4;
    localparam int ST_OVERFLOW  = 5;

endpackage

// File: rtl/tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Byte FIFO feeding the TX valid/ready stream. No bypass: a byte pushed into
// an empty FIFO becomes visible on the following cycle. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (flushes the FIFO)
//   i_push       push request
//   i_push_data  byte to push
//   i_ready      consumer ready; pop when o_valid && i_ready
//   o_push_ok    push request was accepted this cycle
//   o_data       head byte (0 when empty)
//   o_valid      FIFO not empty
//   o_count      number of stored bytes, 0..FIFO_DEPTH
//   o_full       count == FIFO_DEPTH
//   o_empty      count == 0
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_push_data,
    input  logic          i_ready,
    output logic          o_push_ok,
    output logic [7:0]    o_data,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = i_ready && !o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = i_push && (!o_full || w_pop);

    assign o_push_ok = w_push_ok;
    assign o_valid   = !o_empty;
    assign o_count   = r_count;
    // Forced to 0 when empty so the unreset storage never shows on tx_data.
    assign o_data    = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally modulo FIFO_DEPTH.
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push_ok) r_count <= r_count - CW'(1);
        end
    end

    // NOTE: storage arrays are deliberately left out of reset; the pointers
    // and count define validity, and resetting the array would cost a reset
    // net per bit while preventing RAM inference.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory end of the CPU's M-stage interface. Every access completes in
// the cycle it is presented: loads are combinational, stores commit at the
// clock edge. Serves a word-addressed RAM plus an MMIO block (LED, cycle
// counter, store counter, TX FIFO data/status).
//
// Optional feature macro: DMEM_ACCESS_CHECK_EN
//   defined   -> err becomes a sticky flag for misaligned accesses and MMIO
//                accesses to unmapped offsets
//   undefined -> err tied to 0, no check logic
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   memwriteM   store strobe
//   aluoutM     byte address (bits [1:0] ignored for data)
//   writedataM  store data
//   readdataM   load data, combinational
//   tx_data     TX FIFO head byte
//   tx_valid    TX FIFO not empty
//   tx_ready    TX consumer ready
//   led         LED register
//   err         sticky access error flag
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] led,
    output logic        err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0] r_ram [2**RAM_AW];
    logic [15:0] r_led;
    logic [31:0] r_cycle;
    logic [31:0] r_stores;
    logic        r_ovf;

    logic              w_is_mmio;
    logic [15:0]       w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_led;
    logic              w_wr_status;
    logic              w_push;
    logic              w_push_ok;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_status;

    assign w_is_mmio = (aluoutM[31:16] == MMIO_BASE[31:16]);
    // Word offset: the byte-lane bits do not select a register.
    assign w_off     = aluoutM[15:0] & 16'hFFFC;
    // Address bits above the RAM index are dropped, so RAM aliases.
    assign w_ram_idx = aluoutM[RAM_AW+1:2];

    assign w_wr_led    = memwriteM && w_is_mmio && (w_off == OFF_LED);
    assign w_wr_status = memwriteM && w_is_mmio && (w_off == OFF_STATUS);
    assign w_push      = memwriteM && w_is_mmio && (w_off == OFF_TXDATA);

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (writedataM[7:0]),
        .i_ready     (tx_ready),
        .o_push_ok   (w_push_ok),
        .o_data      (tx_data),
        .o_valid     (tx_valid),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // RAM write port; a same-cycle load sees the old word because the read
    // below is combinational from the pre-edge array.
    always_ff @(posedge clk) begin
        if (memwriteM && !w_is_mmio) r_ram[w_ram_idx] <= writedataM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led    <= '0;
            r_cycle  <= '0;
            r_stores <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (memwriteM) r_stores <= r_stores + 32'd1;
            if (w_wr_led)  r_led    <= writedataM[15:0];
            // A STATUS write and a TXDATA push never share a cycle (one address).
            if (w_wr_status)            r_ovf <= 1'b0;
            else if (w_push && !w_push_ok) r_ovf <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_status                            = '0;
        w_status[ST_FULL]                   = w_full;
        w_status[ST_EMPTY]                  = w_empty;
        w_status[ST_COUNT_MSB:ST_COUNT_LSB] = 3'(w_count);
        w_status[ST_OVERFLOW]               = r_ovf;
    end

    always_comb begin
        readdataM = '0;
        if (w_is_mmio) begin
            case (w_off)
                OFF_LED:    readdataM = {16'h0000, r_led};
                OFF_CYCLE:  readdataM = r_cycle;
                OFF_STORES: readdataM = r_stores;
                OFF_STATUS: readdataM = w_status;
                default:    readdataM = '0;
            endcase
        end else begin
            readdataM = r_ram[w_ram_idx];
        end
    end

    assign led = r_led;

`ifdef DMEM_ACCESS_CHECK_EN
    logic r_err;
    logic w_unmapped;
    logic w_access;

    assign w_unmapped = w_is_mmio &&
                        !((w_off == OFF_LED)    || (w_off == OFF_CYCLE)  ||
                          (w_off == OFF_STORES) || (w_off == OFF_TXDATA) ||
                          (w_off == OFF_STATUS));
    // No read strobe exists, so only stores and MMIO-region reads count as
    // accesses; a RAM address on a non-store cycle may be an ALU result.
    assign w_access   = memwriteM || w_is_mmio;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_access && ((aluoutM[1:0] != 2'b00) || w_unmapped))
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Each stimulus cycle asks a
// behavioural model for the outputs expected during that cycle and queues
// them; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] led;
    logic        err;

    dmem_responder #(
        .RAM_AW     (10),
        .FIFO_DEPTH (D),
        .MMIO_BASE  (32'hFFFF_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .led        (led),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          ld;
        logic [31:0] rd;
        bit          v;
        logic [7:0]  td;
        logic [15:0] led;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    logic [31:0] m_ram [int];
    logic [31:0] wr_addrs[$];
    logic [7:0]  m_fifo[$];
    logic [15:0] m_led;
    logic [31:0] m_cycle;
    logic [31:0] m_stores;
    bit          m_ovf;
    bit          m_err;
    bit          model_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:16] == 16'hFFFF;
    endfunction

    function automatic logic [15:0] offset(input logic [31:0] a);
        return {a[15:2], 2'b00};
    endfunction

    function automatic bit mapped(input logic [31:0] a);
        logic [15:0] o;
        o = offset(a);
        return (o == 16'h0) || (o == 16'h4) || (o == 16'h8) || (o == 16'h10) || (o == 16'h14);
    endfunction

    function automatic int ram_idx(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int n;
        n = m_fifo.size();
        if (is_mmio(a)) begin
            case (offset(a))
                16'h0000: return {16'h0000, m_led};
                16'h0004: return m_cycle;
                16'h0008: return m_stores;
                16'h0014: return {26'd0, m_ovf, 3'(n), (n == 0), (n == D)};
                default:  return 32'h0;
            endcase
        end
        if (m_ram.exists(ram_idx(a))) return m_ram[ram_idx(a)];
        return 'x;
    endfunction

    // One bus cycle: drive inputs, queue expectations, advance the model.
    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit rdy, input bit rs, input bit ld);
        exp_t e;
        memwriteM  = we;
        aluoutM    = a;
        writedataM = wd;
        tx_ready   = rdy;
        rst        = rs;

        e.chk = model_ok;
        e.ld  = ld;
        e.rd  = model_read(a);
        e.v   = (m_fifo.size() > 0);
        e.td  = e.v ? m_fifo[0] : 8'h00;
        e.led = m_led;
`ifdef DMEM_ACCESS_CHECK_EN
        e.err = m_err;
`else
        e.err = 1'b0;
`endif
        exp_q.push_back(e);

        if (rs) begin
            m_led    = '0;
            m_cycle  = '0;
            m_stores = '0;
            m_ovf    = 0;
            m_err    = 0;
            m_fifo.delete();
            model_ok = 1;
        end else begin
            m_cycle++;
            if ((m_fifo.size() > 0) && rdy) void'(m_fifo.pop_front());
            if ((we || is_mmio(a)) && ((a[1:0] != 2'b00) || (is_mmio(a) && !mapped(a))))
                m_err = 1;
            if (we) begin
                m_stores++;
                if (!is_mmio(a)) begin
                    m_ram[ram_idx(a)] = wd;
                    wr_addrs.push_back(a);
                end else begin
                    case (offset(a))
                        16'h0000: m_led = wd[15:0];
                        16'h0014: m_ovf = 0;
                        16'h0010: begin
                            if (m_fifo.size() < D) m_fifo.push_back(wd[7:0]);
                            else m_ovf = 1;
                        end
                        default: ;
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) begin
                check("tx_valid", {31'd0, tx_valid}, {31'd0, mon_e.v});
                check("tx_data", {24'd0, tx_data}, {24'd0, mon_e.td});
                check("led", {16'd0, led}, {16'd0, mon_e.led});
                check("err", {31'd0, err}, {31'd0, mon_e.err});
                if (mon_e.ld) check("readdataM", readdataM, mon_e.rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] offs [7];
        int r;
        bit we;
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018};

        rst = 1'b1; memwriteM = 1'b0; aluoutM = '0; writedataM = '0; tx_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles, then five free-running cycles.
        repeat (3) cyc(0, 32'h0, 32'h0, 0, 1, 0);
        repeat (5) cyc(0, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, 32'hFFFF_0004, 32'h0, 0, 0, 1);            // CYCLE == 5

        // RAM: write, read back, read-during-write, alias.
        cyc(1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 0);
        cyc(0, 32'h0000_0040, 32'h0, 0, 0, 1);
        cyc(1, 32'h0000_0040, 32'h1234_5678, 0, 0, 1);    // old DEADBEEF
        cyc(0, 32'h0000_1040, 32'h0, 0, 0, 1);            // alias -> 12345678
        cyc(1, 32'h0000_0080, 32'h0BAD_F00D, 0, 0, 0);
        cyc(0, 32'hFFFF_0008, 32'h0, 0, 0, 1);            // STORES == 3
        cyc(1, 32'hFFFF_0004, 32'hFFFF_FFFF, 0, 0, 0);    // read-only CYCLE
        cyc(0, 32'hFFFF_0004, 32'h0, 0, 0, 1);

        // LED.
        cyc(1, 32'hFFFF_0000, 32'hABCD_1234, 0, 0, 0);
        cyc(0, 32'hFFFF_0000, 32'h0, 0, 0, 1);

        // FIFO fill past full with the consumer stalled.
        for (int b = 8'h41; b <= 8'h45; b++) cyc(1, 32'hFFFF_0010, 32'(b), 0, 0, 0);
        cyc(0, 32'hFFFF_0014, 32'h0, 0, 0, 1);            // full, count 4, ovf
        cyc(0, 32'hFFFF_0010, 32'h0, 0, 0, 1);            // TXDATA reads 0
        cyc(1, 32'hFFFF_0014, 32'h0, 0, 0, 0);            // clear overflow
        cyc(0, 32'hFFFF_0014, 32'h0, 0, 0, 1);

        // Push into a full FIFO while popping, then drain.
        cyc(1, 32'hFFFF_0010, 32'h0000_0055, 1, 0, 0);
        cyc(0, 32'hFFFF_0014, 32'h0, 0, 0, 1);
        repeat (6) cyc(0, 32'h0, 32'h0, 1, 0, 0);
        cyc(0, 32'hFFFF_0014, 32'h0, 0, 0, 1);            // empty

        // Reset mid-stream flushes the FIFO.
        cyc(1, 32'hFFFF_0010, 32'h0000_0066, 0, 0, 0);
        cyc(1, 32'hFFFF_0010, 32'h0000_0077, 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);
        cyc(0, 32'hFFFF_0014, 32'h0, 0, 0, 1);

        // Misaligned store: sets err when the check is built in.
        cyc(1, 32'h0000_0042, 32'hCAFE_F00D, 0, 0, 0);
        repeat (3) cyc(0, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0000_0040, 32'h0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                a = $urandom & 32'h0000_FFFC;
                if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
                cyc(1, a, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0, 0);
            end else if (r < 5 && wr_addrs.size() > 0) begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                cyc(0, a, 32'h0, $urandom_range(0, 1) == 1, 0, 1);
            end else if (r < 8) begin
                a = {16'hFFFF, offs[$urandom_range(0, 6)]};
                we = ($urandom_range(0, 1) == 1);
                cyc(we, a, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0, 1);
            end else begin
                cyc(0, 32'h0, 32'h0, $urandom_range(0, 1) == 1, 0, 0);
            end
        end

        cyc(0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
